xif_coproc_responder: RTL and testbench

- Coprocessor-side responder for the CORE-V-XIF issue/commit/result channels; the counterpart of the CPU-side bridge in core-v-mini-mcu.
- Decodes custom-0 instructions, captures operands, waits for commit, executes over a fixed multi-cycle latency, then returns the writeback result.
- Holds one instruction in flight, matching CV32E20's in-order single-issue offload.
- Sits on the coprocessor ends of the if_xif issue, commit and result modports. Compressed, mem and mem_result are tied off in the parent.

---
 rtl/xif_coproc_pkg.sv | 42 ++++
 rtl/xif_coproc_alu.sv | 40 ++++
 rtl/xif_coproc_responder.sv | 183 ++++++++++++++++++
 tb/tb_xif_coproc_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_coproc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xif_coproc_pkg
// Purpose  : Shared types and constants for the CORE-V-XIF coprocessor
//            responder (state encoding, op selectors, captured op record).
// Revision : 1.0 - initial release
// ============================================================================
package xif_coproc_pkg;

  // Storage widths of the captured op record; the top truncates to its
  // own parameter widths on the way out.
  localparam int C_RFR_WIDTH    = 32;
  localparam int C_ID_MAX_WIDTH = 32;

  // funct3 selectors of the supported custom-0 operations
  localparam logic [2:0] C_OP_ADD    = 3'b000;
  localparam logic [2:0] C_OP_XOR    = 3'b001;
  localparam logic [2:0] C_OP_POPCNT = 3'b010;
  localparam logic [2:0] C_OP_ACC    = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_COMMIT = 2'd1,
    ST_EXEC        = 2'd2,
    ST_RESULT      = 2'd3
  } xif_coproc_state_e;

  typedef struct packed {
    logic [2:0]                funct3;
    logic [4:0]                rd;
    logic [C_ID_MAX_WIDTH-1:0] id;
    logic [C_RFR_WIDTH-1:0]    rs1;
    logic [C_RFR_WIDTH-1:0]    rs2;
  } xif_coproc_op_t;

  // Only funct3 values 000..011 are implemented.
  function automatic logic op_supported(input logic [2:0] funct3);
    return (funct3[2] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xif_coproc_alu.sv
`default_nettype none
// ============================================================================
// Module   : xif_coproc_alu
// Purpose  : Combinational evaluation of the custom-0 operations.
// Revision : 1.0 - initial release
// ============================================================================
module xif_coproc_alu
  import xif_coproc_pkg::*;
(
  input  logic [2:0]             funct3_i,
  input  logic [C_RFR_WIDTH-1:0] rs1_i,
  input  logic [C_RFR_WIDTH-1:0] rs2_i,
  input  logic [C_RFR_WIDTH-1:0] acc_i,
  output logic [C_RFR_WIDTH-1:0] result_o
);

  logic [C_RFR_WIDTH-1:0] w_popcnt;

  // Population count of rs1, zero-extended to the register width
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < C_RFR_WIDTH; i++) begin
      w_popcnt = w_popcnt + C_RFR_WIDTH'(rs1_i[i]);
    end
  end

  // Operation select; ACC returns the would-be new accumulator value
  always_comb begin
    result_o = '0;
    case (funct3_i)
      C_OP_ADD:    result_o = rs1_i + rs2_i;
      C_OP_XOR:    result_o = rs1_i ^ rs2_i;
      C_OP_POPCNT: result_o = w_popcnt;
      C_OP_ACC:    result_o = acc_i + rs1_i;
      default:     result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/xif_coproc_responder.sv
`default_nettype none
// ============================================================================
// Module   : xif_coproc_responder
// Purpose  : CORE-V-XIF coprocessor responder. Accepts one custom-0
//            instruction at a time, waits for its commit, executes for a
//            fixed latency and returns the writeback result.
// Revision : 1.0 - initial release
// ============================================================================
module xif_coproc_responder
  import xif_coproc_pkg::*;
#(
  parameter int         X_ID_WIDTH   = 4,
  parameter int         X_RFR_WIDTH  = 32,
  parameter int         EXEC_LATENCY = 2,
  parameter logic [6:0] OPCODE       = 7'b0001011
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]    issue_id_i,
  input  logic [2*X_RFR_WIDTH-1:0] issue_rs_i,
  input  logic [1:0]               issue_rs_valid_i,
  output logic                     issue_accept_o,
  output logic                     issue_writeback_o,
  input  logic                     commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]    commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [X_RFR_WIDTH-1:0]   result_data_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,
  output logic                     busy_o
);

  // Remaining execute cycles after the commit cycle itself
  localparam logic [3:0] C_LAT_M1 = 4'(EXEC_LATENCY - 1);

  xif_coproc_state_e      state_q, state_d;
  xif_coproc_op_t         op_q, op_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [C_RFR_WIDTH-1:0] acc_q, acc_d;
  logic [C_RFR_WIDTH-1:0] result_q, result_d;

  xif_coproc_op_t         w_new_op;
  xif_coproc_op_t         w_exec_op;
  logic                   w_match;
  logic                   w_issue_ready;
  logic                   w_accept_hs;
  logic [X_ID_WIDTH-1:0]  w_commit_ref_id;
  logic                   w_commit_hit;
  logic [C_RFR_WIDTH-1:0] w_alu_result;
  logic                   w_go;
  logic                   w_finish;
  logic                   w_in_result;
  logic                   unused_ok;

  // Decode and issue handshake; outputs held low while in reset
  always_comb begin
    w_match = rst_ni && (issue_instr_i[6:0] == OPCODE) &&
              (issue_instr_i[31:25] == 7'd0) && op_supported(issue_instr_i[14:12]);
    w_issue_ready = rst_ni && (state_q == ST_IDLE) &&
                    (!w_match || (issue_rs_valid_i == 2'b11));
    w_accept_hs = issue_valid_i && w_issue_ready && w_match;

    w_new_op.funct3 = issue_instr_i[14:12];
    w_new_op.rd     = issue_instr_i[11:7];
    w_new_op.id     = C_ID_MAX_WIDTH'(issue_id_i);
    w_new_op.rs1    = C_RFR_WIDTH'(issue_rs_i[X_RFR_WIDTH-1:0]);
    w_new_op.rs2    = C_RFR_WIDTH'(issue_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH]);

    // In IDLE the op is still on the issue bus (same-cycle commit case)
    w_exec_op       = (state_q == ST_IDLE) ? w_new_op : op_q;
    w_commit_ref_id = (state_q == ST_IDLE) ? issue_id_i : op_q.id[X_ID_WIDTH-1:0];
    w_commit_hit    = commit_valid_i && (commit_id_i == w_commit_ref_id);
  end

  xif_coproc_alu u_alu (
    .funct3_i (w_exec_op.funct3),
    .rs1_i    (w_exec_op.rs1),
    .rs2_i    (w_exec_op.rs2),
    .acc_i    (acc_q),
    .result_o (w_alu_result)
  );

  // Next-state logic: the commit cycle counts as the first execute cycle,
  // so completion lands the result exactly EXEC_LATENCY cycles later
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    w_go     = 1'b0;
    w_finish = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_accept_hs) begin
          op_d = w_new_op;
          if (w_commit_hit) begin
            w_go = !commit_kill_i;
          end else begin
            state_d = ST_WAIT_COMMIT;
          end
        end
      end
      ST_WAIT_COMMIT: begin
        if (w_commit_hit) begin
          if (commit_kill_i) begin
            state_d = ST_IDLE;
          end else begin
            w_go = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          w_finish = 1'b1;
        end
      end
      ST_RESULT: begin
        if (result_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_go) begin
      state_d = ST_EXEC;
      cnt_d   = C_LAT_M1;
      if (C_LAT_M1 == 4'd0) begin
        w_finish = 1'b1;
      end
    end

    if (w_finish) begin
      state_d  = ST_RESULT;
      result_d = w_alu_result;
      if (w_exec_op.funct3 == C_OP_ACC) begin
        acc_d = w_alu_result;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign w_in_result       = (state_q == ST_RESULT);
  assign issue_ready_o     = w_issue_ready;
  assign issue_accept_o    = w_match;
  assign issue_writeback_o = w_match;
  assign result_valid_o    = w_in_result;
  assign result_we_o       = w_in_result;
  assign result_id_o       = w_in_result ? op_q.id[X_ID_WIDTH-1:0] : '0;
  assign result_rd_o       = w_in_result ? op_q.rd : '0;
  assign result_data_o     = w_in_result ? X_RFR_WIDTH'(result_q) : '0;
  assign busy_o            = (state_q != ST_IDLE);

  // Register-specifier fields and spare record bits are not needed here
  assign unused_ok = ^{issue_instr_i[24:15], op_q, w_exec_op};

endmodule
`default_nettype wire

// File: tb/tb_xif_coproc_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_xif_coproc_responder
// Purpose  : Self-checking bench for xif_coproc_responder with a behavioural
//            reference model of the custom-0 operations and accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xif_coproc_responder;

  localparam int         X_ID_WIDTH   = 4;
  localparam int         X_RFR_WIDTH  = 32;
  localparam int         EXEC_LATENCY = 2;
  localparam logic [6:0] OPCODE       = 7'b0001011;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [31:0]              issue_instr_i;
  logic [X_ID_WIDTH-1:0]    issue_id_i;
  logic [2*X_RFR_WIDTH-1:0] issue_rs_i;
  logic [1:0]               issue_rs_valid_i;
  logic                     issue_accept_o;
  logic                     issue_writeback_o;
  logic                     commit_valid_i;
  logic [X_ID_WIDTH-1:0]    commit_id_i;
  logic                     commit_kill_i;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic [X_ID_WIDTH-1:0]    result_id_o;
  logic [X_RFR_WIDTH-1:0]   result_data_o;
  logic [4:0]               result_rd_o;
  logic                     result_we_o;
  logic                     busy_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_acc;

  always #5 clk_i = ~clk_i;

  xif_coproc_responder #(
    .X_ID_WIDTH   (X_ID_WIDTH),
    .X_RFR_WIDTH  (X_RFR_WIDTH),
    .EXEC_LATENCY (EXEC_LATENCY),
    .OPCODE       (OPCODE)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs_i        (issue_rs_i),
    .issue_rs_valid_i  (issue_rs_valid_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_data_o     (result_data_o),
    .result_rd_o       (result_rd_o),
    .result_we_o       (result_we_o),
    .busy_o            (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    issue_rs_i       = '0;
    issue_rs_valid_i = 2'b00;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
    result_ready_i   = 1'b0;
  endtask

  function automatic logic [31:0] make_instr(input logic [2:0] f3, input logic [4:0] rd);
    logic [9:0] regs;
    regs = 10'($urandom);
    return {7'b0000000, regs, f3, rd, OPCODE};
  endfunction

  // Reference semantics of the four operations
  function automatic logic [31:0] model_eval(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] acc);
    logic [32:0] sum;
    case (f3)
      3'd0: begin sum = {1'b0, a} + {1'b0, b}; return sum[31:0]; end
      3'd1: return a ^ b;
      3'd2: return 32'($countones(a));
      default: begin sum = {1'b0, acc} + {1'b0, a}; return sum[31:0]; end
    endcase
  endfunction

  // One full transaction: issue, optional stray commit, commit, result drain
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                        input logic [31:0] rs1, input logic [31:0] rs2, input bit same_cycle,
                        input bit kill, input bit wrong_first, input int stall, input string tag);
    logic [31:0] instr;
    logic [31:0] exp_data;
    int          n;
    instr            = make_instr(f3, rd);
    issue_valid_i    = 1'b1;
    issue_instr_i    = instr;
    issue_id_i       = id;
    issue_rs_i       = {rs2, rs1};
    issue_rs_valid_i = 2'b11;
    if (same_cycle) begin
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
    end
    #1;
    check({tag, " issue_ready"}, 64'(issue_ready_o), 64'd1);
    check({tag, " accept"}, 64'({issue_accept_o, issue_writeback_o}), 64'd3);
    tick();
    issue_valid_i    = 1'b0;
    issue_rs_valid_i = 2'b00;
    commit_valid_i   = 1'b0;
    commit_kill_i    = 1'b0;
    if (!same_cycle) begin
      check({tag, " busy_wait"}, 64'(busy_o), 64'd1);
      if (wrong_first) begin
        commit_valid_i = 1'b1;
        commit_id_i    = id ^ 4'h7;
        commit_kill_i  = 1'b1;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
        check({tag, " wrong_id_ignored"}, 64'({busy_o, result_valid_o}), 64'b10);
      end
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      tick();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
    end
    n = 1;
    if (kill) begin
      check({tag, " killed_idle"}, 64'(busy_o), 64'd0);
      repeat (EXEC_LATENCY + 2) begin
        tick();
        if (result_valid_o !== 1'b0) n = 0;
      end
      check({tag, " killed_no_result"}, 64'(n), 64'd1);
      return;
    end
    exp_data = model_eval(f3, rs1, rs2, model_acc);
    if (f3 == 3'd3) model_acc = exp_data;
    while (result_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(EXEC_LATENCY));
    check({tag, " data"}, 64'(result_data_o), 64'(exp_data));
    check({tag, " id_rd_we"}, 64'({result_id_o, result_rd_o, result_we_o}), 64'({id, rd, 1'b1}));
    issue_instr_i = {7'b0, 10'h0, 3'b000, 5'd1, 7'b0110011};
    #1;
    check({tag, " ready_in_result"}, 64'(issue_ready_o), 64'd0);
    for (int k = 0; k < stall; k++) begin
      result_ready_i = 1'b0;
      tick();
      check($sformatf("%s hold%0d", tag, k),
            64'({result_valid_o, issue_ready_o, result_data_o}), 64'({2'b10, exp_data}));
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    issue_instr_i  = '0;
    check({tag, " drained"}, 64'({result_valid_o, busy_o}), 64'd0);
  endtask

  initial begin
    idle_inputs();
    rst_ni    = 1'b0;
    model_acc = '0;
    tick();
    tick();
    check("reset_outputs", 64'({issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
          result_id_o, result_data_o, result_rd_o, result_we_o, busy_o}), 64'd0);
    rst_ni = 1'b1;
    tick();

    // ADD wrap-around with commit on the following cycle
    run_op(3'd0, 5'd9, 4'd3, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0, 0, "add");

    // Non-matching opcode is ready but rejected
    issue_valid_i = 1'b1;
    issue_instr_i = {7'b0, 10'h0, 3'b000, 5'd1, 7'b0110011};
    #1;
    check("nonmatch ready_accept", 64'({issue_ready_o, issue_accept_o, issue_writeback_o}), 64'b100);
    tick();
    issue_valid_i = 1'b0;
    check("nonmatch busy", 64'(busy_o), 64'd0);
    tick();

    // Killed ACC leaves the accumulator alone
    run_op(3'd3, 5'd4, 4'd1, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 0, "acc_kill");
    run_op(3'd3, 5'd4, 4'd2, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 0, "acc_after_kill");
    check("acc_after_kill model", 64'(model_acc), 64'd7);

    // Back-pressure on the result channel
    run_op(3'd2, 5'd11, 4'd4, 32'hF0F0_0001, 32'd0, 1'b0, 1'b0, 1'b0, 5, "popcnt_bp");

    // Same-cycle commit, then a stray commit id before the real one
    run_op(3'd1, 5'd12, 4'd9, 32'h0000_00A5, 32'h0000_000F, 1'b1, 1'b0, 1'b0, 0, "xor_same");
    run_op(3'd0, 5'd13, 4'd5, 32'd100, 32'd23, 1'b0, 1'b0, 1'b1, 0, "wrong_id");

    // Matching instruction without both operands is held off
    issue_valid_i    = 1'b1;
    issue_instr_i    = make_instr(3'd0, 5'd2);
    issue_rs_valid_i = 2'b01;
    #1;
    check("rs_not_valid ready", 64'(issue_ready_o), 64'd0);
    tick();
    idle_inputs();
    check("rs_not_valid busy", 64'(busy_o), 64'd0);

    // Randomized transactions against the model
    for (int i = 0; i < 25; i++) begin
      bit same;
      same = 1'($urandom_range(0, 1));
      run_op(3'($urandom_range(0, 3)), 5'($urandom), 4'($urandom), $urandom, $urandom,
             same, ($urandom_range(0, 3) == 0), (!same && ($urandom_range(0, 1) == 1)),
             int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    // Reset while executing an ACC clears state and the accumulator
    issue_valid_i    = 1'b1;
    issue_instr_i    = make_instr(3'd3, 5'd6);
    issue_id_i       = 4'd6;
    issue_rs_i       = {32'd0, 32'h0000_1234};
    issue_rs_valid_i = 2'b11;
    commit_valid_i   = 1'b1;
    commit_id_i      = 4'd6;
    tick();
    idle_inputs();
    check("mid_exec busy", 64'({busy_o, result_valid_o}), 64'b10);
    rst_ni = 1'b0;
    tick();
    check("mid_exec reset_outputs", 64'({issue_ready_o, issue_accept_o, issue_writeback_o,
          result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, busy_o}), 64'd0);
    rst_ni    = 1'b1;
    model_acc = '0;
    tick();
    run_op(3'd3, 5'd7, 4'd8, 32'h0000_0042, 32'd0, 1'b0, 1'b0, 1'b0, 0, "acc_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
